// File: rtl/alien_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alien_fire_scheduler
// Brief    : Paces alien shots by frame count, picks a pseudo-random column,
//            scans it bottom-up for the lowest living alien, issues a spawn.
// Revision : 1.0 - initial release
// ============================================================================
module alien_fire_scheduler #(
    parameter int         ALIEN_ROW          = 4,
    parameter int         ALIEN_COLUMN       = 8,
    parameter int         ALIEN_PITCH_X      = 48,
    parameter int         ALIEN_PITCH_Y      = 32,
    parameter int         ALIEN_HEIGHT       = 24,
    parameter int         SHOT_X_OFFSET      = 15,
    parameter int         FIRE_PERIOD_FRAMES = 45,
    parameter logic [7:0] LFSR_SEED          = 8'hA5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              startOfFrame,
    input  logic                              playGame,
    input  logic [ALIEN_ROW*ALIEN_COLUMN-1:0] aliveMatrix,
    input  logic signed [10:0]                gridX,
    input  logic signed [10:0]                gridY,
    input  logic [1:0]                        slotBusy,
    output logic                              spawnValid,
    output logic                              spawnSlot,
    output logic signed [10:0]                spawnX,
    output logic signed [10:0]                spawnY,
    output logic                              schedBusy
);

    localparam int c_COL_W = (ALIEN_COLUMN > 1) ? $clog2(ALIEN_COLUMN) : 1;
    localparam int c_ROW_W = (ALIEN_ROW > 1) ? $clog2(ALIEN_ROW) : 1;
    localparam int c_TRY_W = $clog2(ALIEN_COLUMN + 1);
    localparam int c_CELLS = ALIEN_ROW * ALIEN_COLUMN;
    localparam int c_IDX_W = (c_CELLS > 1) ? $clog2(c_CELLS) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(ALIEN_COLUMN - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(ALIEN_ROW - 1);
    localparam logic [c_TRY_W-1:0] c_TRY_DONE = c_TRY_W'(ALIEN_COLUMN);
    localparam logic [7:0]         c_PERIOD   = 8'(FIRE_PERIOD_FRAMES);

    localparam logic [2:0] c_COOLDOWN  = 3'd0;
    localparam logic [2:0] c_WAIT_SLOT = 3'd1;
    localparam logic [2:0] c_PICK      = 3'd2;
    localparam logic [2:0] c_SCAN      = 3'd3;
    localparam logic [2:0] c_FIRE      = 3'd4;

    logic [2:0]         r_state;
    logic [7:0]         r_frame_cnt;
    logic [7:0]         r_lfsr;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_TRY_W-1:0] r_tries;
    logic [10:0]        r_hit_x;
    logic [10:0]        r_hit_y;

    logic               w_rst;
    logic               w_lfsr_fb;
    logic [c_COL_W-1:0] w_pick_col;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_alive;
    logic [c_TRY_W-1:0] w_tries_next;
    logic [10:0]        w_pos_x;
    logic [10:0]        w_pos_y;

    assign w_rst        = reset | ~playGame;
    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    // Column count is a power of two, so the modulo is just the low LFSR bits.
    assign w_pick_col   = (ALIEN_COLUMN == 1) ? '0 : r_lfsr[c_COL_W-1:0];
    assign w_idx        = c_IDX_W'(r_row) * c_IDX_W'(ALIEN_COLUMN) + c_IDX_W'(r_col);
    assign w_alive      = aliveMatrix[w_idx];
    assign w_tries_next = r_tries + c_TRY_W'(1);

    // The low 11 bits of the 16-bit signed sum depend only on the low 11 bits
    // of each operand, so the wrap is computed directly at output width.
    assign w_pos_x = gridX + 11'(r_col) * 11'(ALIEN_PITCH_X) + 11'(SHOT_X_OFFSET);
    assign w_pos_y = gridY + 11'(r_row) * 11'(ALIEN_PITCH_Y) + 11'(ALIEN_HEIGHT);

    assign schedBusy = (r_state != c_COOLDOWN);

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state     <= c_COOLDOWN;
            r_frame_cnt <= c_PERIOD;
            r_lfsr      <= LFSR_SEED;
            r_col       <= '0;
            r_row       <= '0;
            r_tries     <= '0;
            r_hit_x     <= '0;
            r_hit_y     <= '0;
            spawnValid  <= 1'b0;
            spawnSlot   <= 1'b0;
            spawnX      <= '0;
            spawnY      <= '0;
        end else begin
            r_lfsr     <= {r_lfsr[6:0], w_lfsr_fb};
            spawnValid <= 1'b0;
            case (r_state)
                c_COOLDOWN: begin
                    if (startOfFrame) begin
                        if (r_frame_cnt == 8'd1) begin
                            r_frame_cnt <= c_PERIOD;
                            r_state     <= c_WAIT_SLOT;
                        end else begin
                            r_frame_cnt <= r_frame_cnt - 8'd1;
                        end
                    end
                end
                c_WAIT_SLOT: begin
                    if (slotBusy != 2'b11) begin
                        r_state <= c_PICK;
                    end
                end
                c_PICK: begin
                    r_col   <= w_pick_col;
                    r_row   <= c_ROW_LAST;
                    r_tries <= '0;
                    r_state <= c_SCAN;
                end
                c_SCAN: begin
                    if (w_alive) begin
                        r_hit_x <= w_pos_x;
                        r_hit_y <= w_pos_y;
                        r_state <= c_FIRE;
                    end else if (r_row != '0) begin
                        r_row <= r_row - c_ROW_W'(1);
                    end else begin
                        r_col   <= (r_col == c_COL_LAST) ? '0 : r_col + c_COL_W'(1);
                        r_row   <= c_ROW_LAST;
                        r_tries <= w_tries_next;
                        if (w_tries_next == c_TRY_DONE) begin
                            r_state <= c_COOLDOWN;
                        end
                    end
                end
                c_FIRE: begin
                    // Both slots may have filled since the scan began; retry later.
                    if (slotBusy == 2'b11) begin
                        r_state <= c_WAIT_SLOT;
                    end else begin
                        spawnValid <= 1'b1;
                        spawnSlot  <= slotBusy[0];
                        spawnX     <= r_hit_x;
                        spawnY     <= r_hit_y;
                        r_state    <= c_COOLDOWN;
                    end
                end
                default: r_state <= c_COOLDOWN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alien_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alien_fire_scheduler
// Brief    : Directed self-checking bench for alien_fire_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alien_fire_scheduler;

    logic               clk = 1'b0;
    logic               reset;
    logic               startOfFrame;
    logic               playGame;
    logic [31:0]        aliveMatrix;
    logic signed [10:0] gridX;
    logic signed [10:0] gridY;
    logic [1:0]         slotBusy;
    logic               spawnValid;
    logic               spawnSlot;
    logic signed [10:0] spawnX;
    logic signed [10:0] spawnY;
    logic               schedBusy;

    int         checks    = 0;
    int         failures  = 0;
    int         valid_cnt = 0;
    int         lat;
    int         busy_n;
    logic [7:0] m_lfsr;
    logic [7:0] n2;
    logic       found;

    always #5 clk = ~clk;

    alien_fire_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .playGame     (playGame),
        .aliveMatrix  (aliveMatrix),
        .gridX        (gridX),
        .gridY        (gridY),
        .slotBusy     (slotBusy),
        .spawnValid   (spawnValid),
        .spawnSlot    (spawnSlot),
        .spawnX       (spawnX),
        .spawnY       (spawnY),
        .schedBusy    (schedBusy)
    );

    function automatic logic [7:0] adv(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reference LFSR, free-running from the seed outside reset.
    always @(posedge clk) begin
        if (reset || !playGame) m_lfsr <= 8'hA5;
        else                    m_lfsr <= adv(m_lfsr);
    end

    always @(posedge clk) begin
        if (spawnValid) valid_cnt <= valid_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            sof_pulse();
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int max, output int l);
        l = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (spawnValid) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic busy_run(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!schedBusy) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        playGame     = 1'b1;
        startOfFrame = 1'b0;
        aliveMatrix  = '0;
        gridX        = '0;
        gridY        = '0;
        slotBusy     = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(spawnValid), 0);
        chk("rst_slot",  int'(spawnSlot),  0);
        chk("rst_x",     int'(spawnX),     0);
        chk("rst_y",     int'(spawnY),     0);
        chk("rst_busy",  int'(schedBusy),  0);
        reset = 1'b0;

        // Single alien at row 2, col 5
        aliveMatrix = 32'h0020_0000;
        gridX = 11'sd100;
        gridY = 11'sd40;
        pulses(44);
        @(negedge clk);
        chk("pre_expiry_valid", valid_cnt, 0);
        chk("pre_expiry_busy",  int'(schedBusy), 0);
        sof_pulse();
        chk("expiry_busy", int'(schedBusy), 1);
        wait_valid(35, lat);
        chk("t2_latency_ok", int'(lat >= 4 && lat <= 35), 1);
        chk("t2_x",    int'(spawnX), 355);
        chk("t2_y",    int'(spawnY), 128);
        chk("t2_slot", int'(spawnSlot), 0);
        chk("t2_idle_at_fire", int'(schedBusy), 0);
        @(negedge clk);
        chk("t2_pulse_width", int'(spawnValid), 0);
        chk("t2_pulse_count", valid_cnt, 1);

        // Empty grid: full fruitless scan
        aliveMatrix = '0;
        pulses(44);
        sof_pulse();
        busy_run(busy_n);
        chk("t3_busy_cycles", busy_n, 34);
        chk("t3_no_valid", valid_cnt, 1);
        chk("t3_hold_x", int'(spawnX), 355);
        pulses(44);
        @(negedge clk);
        chk("t3_reload_44", int'(schedBusy), 0);
        sof_pulse();
        chk("t3_reload_45", int'(schedBusy), 1);
        busy_run(busy_n);
        chk("t3_busy_cycles2", busy_n, 34);

        // Both slots busy at expiry, then slot 1 still busy
        aliveMatrix = 32'h0020_0000;
        slotBusy    = 2'b11;
        pulses(44);
        sof_pulse();
        repeat (100) @(negedge clk);
        chk("t4_wait_busy",  int'(schedBusy), 1);
        chk("t4_wait_novalid", valid_cnt, 1);
        slotBusy = 2'b10;
        wait_valid(35, lat);
        chk("t4_latency_ok", int'(lat >= 4 && lat <= 35), 1);
        chk("t4_slot0", int'(spawnSlot), 0);
        chk("t4_x",     int'(spawnX), 355);
        @(negedge clk);
        slotBusy = 2'b01;
        pulses(44);
        sof_pulse();
        wait_valid(36, lat);
        chk("t4b_latency_ok", int'(lat >= 4 && lat <= 36), 1);
        chk("t4b_slot1", int'(spawnSlot), 1);
        chk("t4b_y",     int'(spawnY), 128);
        @(negedge clk);
        chk("t4_pulse_count", valid_cnt, 3);

        // playGame dropped mid-scan
        aliveMatrix = '0;
        slotBusy    = 2'b00;
        pulses(44);
        sof_pulse();
        repeat (6) @(negedge clk);
        chk("t5_scanning", int'(schedBusy), 1);
        playGame = 1'b0;
        @(negedge clk);
        playGame = 1'b1;
        chk("t5_busy",  int'(schedBusy),  0);
        chk("t5_valid", int'(spawnValid), 0);
        chk("t5_slot",  int'(spawnSlot),  0);
        chk("t5_x",     int'(spawnX),     0);
        chk("t5_y",     int'(spawnY),     0);
        pulses(44);
        @(negedge clk);
        chk("t5_reload_44", int'(schedBusy), 0);
        sof_pulse();
        chk("t5_reload_45", int'(schedBusy), 1);
        busy_run(busy_n);
        chk("t5_no_valid", valid_cnt, 3);

        // Only row 3, col 0 alive; time expiry so the LFSR picks col 7
        aliveMatrix = 32'h0100_0000;
        gridX = 11'sd1020;
        gridY = -11'sd20;
        pulses(44);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            n2 = adv(adv(m_lfsr));
            if (n2[2:0] == 3'd7) begin
                sof_pulse();
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_col7_found", int'(found), 1);
        wait_valid(40, lat);
        chk("t6_latency", lat, 8);
        chk("t6_x_wrap", int'(spawnX), -1013);
        chk("t6_y",      int'(spawnY), 100);
        chk("t6_slot",   int'(spawnSlot), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
